// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: gap low cycles then width high cycles, num_pulses times.
// Optional continuous repeat via `define PULSE_TRAIN_GEN_REPEAT_EN (adds input repeat_train).
module pulse_train_gen #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
`ifdef PULSE_TRAIN_GEN_REPEAT_EN
  input  logic             repeat_train,
`endif
  input  logic [CNT_W-1:0] width_cycles,
  input  logic [CNT_W-1:0] gap_cycles,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_count
);

  typedef enum logic [1:0] {IDLE, GAP, HIGH} state_t;

  state_t           state;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_q;
  logic [NUM_W-1:0] num_q;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] width_eff;
  logic [CNT_W-1:0] gap_eff;
  logic [NUM_W:0]   pc_inc;
  logic [NUM_W-1:0] pc_sat;
  logic             last_pulse;

  always_comb begin
    width_eff  = (width_cycles == '0) ? CNT_W'(1) : width_cycles;
    gap_eff    = (gap_cycles == '0) ? CNT_W'(1) : gap_cycles;
    pc_inc     = {1'b0, pulse_count} + 1'b1;
    pc_sat     = (&pulse_count) ? pulse_count : pc_inc[NUM_W-1:0];
    last_pulse = !(pc_inc < {1'b0, num_q});
  end

  assign busy = (state != IDLE);

  // The counter reloads with value-1 at each phase change and exits on zero.
  // The launch GAP loads the full gap value, which absorbs the latch cycle so
  // the first rise lands one cycle after start + gap.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      out         <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
      width_q     <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        out   <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              width_q     <= width_eff;
              gap_q       <= gap_eff;
              num_q       <= num_pulses;
              pulse_count <= '0;
              if (num_pulses == '0) begin
                done <= 1'b1;
              end else begin
                state <= GAP;
                cnt   <= gap_eff;
              end
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state <= HIGH;
              out   <= 1'b1;
              cnt   <= width_q - 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              out         <= 1'b0;
              cnt         <= gap_q - 1'b1;
              pulse_count <= pc_sat;
              if (!last_pulse) begin
                state <= GAP;
              end else begin
                done <= 1'b1;
`ifdef PULSE_TRAIN_GEN_REPEAT_EN
                if (repeat_train) begin
                  state       <= GAP;
                  pulse_count <= '0;
                end else begin
                  state <= IDLE;
                end
`else
                state <= IDLE;
`endif
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: stimulus queues expected pulse/done events,
// a negedge monitor measures each pulse (high length, preceding low length) and done strobes.
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
`ifdef PULSE_TRAIN_GEN_REPEAT_EN
  logic        repeat_train;
`endif
  logic [31:0] width_cycles;
  logic [31:0] gap_cycles;
  logic [15:0] num_pulses;
  logic        out;
  logic        busy;
  logic        done;
  logic [15:0] pulse_count;

  always #5 clk = ~clk;

  pulse_train_gen #(.CNT_W(32), .NUM_W(16)) dut (
    .clk_in      (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
`ifdef PULSE_TRAIN_GEN_REPEAT_EN
    .repeat_train(repeat_train),
`endif
    .width_cycles(width_cycles),
    .gap_cycles  (gap_cycles),
    .num_pulses  (num_pulses),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .pulse_count (pulse_count)
  );

  // kind 0: pulse (a = high cycles, b = low cycles before it); kind 1: done (a = pulse_count)
  typedef struct packed {
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic emit(input int k, input int a, input int b);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d, expected no event", k, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        failures++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d, expected kind=%0d a=%0d b=%0d",
                 k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor: counts low run since launch (or since last fall) and high run per pulse.
  int prev_out = 0;
  int low_run  = 0;
  int high_run = 0;
  int cap_low  = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_out = 0;
      low_run  = 0;
      high_run = 0;
    end else begin
      if (out) begin
        if (prev_out == 0) begin
          cap_low  = low_run;
          high_run = 1;
        end else begin
          high_run++;
        end
      end else if (prev_out == 1) begin
        emit(0, high_run, cap_low);
        low_run = 1;
      end else if (start && !busy && !abort) begin
        low_run = 0;
      end else begin
        low_run++;
      end
      if (done) begin
        done_seen++;
        emit(1, int'(pulse_count), 0);
      end
      prev_out = out ? 1 : 0;
    end
  end

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic push_pulse(input int w, input int low);
    exp_q.push_back('{kind: 0, a: w, b: low});
  endtask

  task automatic push_done(input int pc);
    exp_q.push_back('{kind: 1, a: pc, b: 0});
  endtask

  task automatic push_train(input int g, input int w, input int n);
    for (int i = 0; i < n; i++)
      push_pulse(eff(w), (i == 0) ? eff(g) + 1 : eff(g));
    push_done(n);
  endtask

  // Called aligned at posedge+1; start is sampled on the next edge.
  task automatic launch(input int g, input int w, input int n);
    gap_cycles   = 32'(g);
    width_cycles = 32'(w);
    num_pulses   = 16'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, int'(busy), 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    int rises;
    int n;
    int pv;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef PULSE_TRAIN_GEN_REPEAT_EN
    repeat_train = 1'b0;
`endif
    width_cycles = 32'd9; gap_cycles = 32'd9; num_pulses = 16'd9;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", int'(out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_pulse_count", int'(pulse_count), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero gap/width -> 1; inputs changed after the latch must not matter.
    push_train(0, 0, 3);
    launch(0, 0, 3);
    check("busy_after_start", int'(busy), 1);
    width_cycles = 32'd7; gap_cycles = 32'd9; num_pulses = 16'd1;
    wait_idle("idle_min_train", 50);
    check("pc_min_train", int'(pulse_count), 3);

    // num_pulses = 0: no pulse, done one cycle after start, never busy.
    push_done(0);
    launch(4, 4, 0);
    check("busy_zero_train", int'(busy), 0);
    @(posedge clk); #1;
    check("busy_zero_train_later", int'(busy), 0);
    wait_idle("idle_zero_train", 10);

    // General two-pulse pattern.
    push_train(3, 5, 2);
    launch(3, 5, 2);
    wait_idle("idle_small_train", 100);
    check("pc_small_train", int'(pulse_count), 2);

    // Abort 10 cycles into the 2nd HIGH; a start mid-train is ignored.
    push_pulse(20, 5);
    push_pulse(10, 4);
    launch(4, 20, 5);
    repeat (3) begin @(posedge clk); #1; end
    gap_cycles = 32'd1; width_cycles = 32'd1; num_pulses = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rises = 0; n = 0; pv = int'(out);
    while (rises < 2 && n < 200) begin
      @(posedge clk); #1;
      if (out && pv == 0) rises++;
      pv = int'(out);
      n++;
    end
    check("second_rise_seen", rises, 2);
    repeat (9) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_out", int'(out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_pulse_count", int'(pulse_count), 1);
    repeat (3) begin @(posedge clk); #1; end

    // abort beats start in IDLE.
    gap_cycles = 32'd2; width_cycles = 32'd2; num_pulses = 16'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", int'(busy), 0);
    repeat (6) begin @(posedge clk); #1; end
    check("abort_start_out", int'(out), 0);

    // rst during the second gap, then a normal launch.
    push_pulse(3, 6);
    launch(5, 3, 3);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pulse_count", int'(pulse_count), 0);
    repeat (2) begin @(posedge clk); #1; end
    push_train(2, 3, 1);
    launch(2, 3, 1);
    wait_idle("idle_after_rst", 50);
    check("pc_after_rst", int'(pulse_count), 1);

    // Long gap/width train.
    push_train(1350, 135, 30);
    launch(1350, 135, 30);
    wait_idle("idle_long_train", 50000);
    check("pc_long_train", int'(pulse_count), 30);

`ifdef PULSE_TRAIN_GEN_REPEAT_EN
    // Continuous repeat: back-to-back trains, pulse_count cleared at each done.
    push_pulse(2, 3); push_pulse(2, 2); push_done(0);
    push_pulse(2, 2); push_pulse(2, 2); push_done(0);
    repeat_train = 1'b1;
    pv = done_seen;
    launch(2, 2, 2);
    n = 0;
    while (done_seen < pv + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("repeat_dones", done_seen - pv, 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat_train = 1'b0;
    check("repeat_abort_busy", int'(busy), 0);
    repeat (6) begin @(posedge clk); #1; end
    check("repeat_abort_out", int'(out), 0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
